// File: rtl/multisim_server_push_mc.sv
// multisim_server_push_mc: per-channel push FIFOs drained round-robin, one server send per cycle.
// Define MULTISIM_SERVER_PUSH_MC_STATS_EN for per-channel sent/rejected/full_cycles counters and a final report.

package multisim_server_push_mc_pkg;
  // Behavioural stand-in for the multisim server DPI boundary; every call is logged.
  localparam int unsigned MAX_DATA_WIDTH = 1024;

  typedef struct {
    string                     name;
    bit [MAX_DATA_WIDTH-1:0]   data;
    bit                        accepted;
  } send_rec_t;

  string     start_log[$];
  send_rec_t send_log[$];
  bit        reject[string];

  function automatic int multisim_server_start(input string name);
    start_log.push_back(name);
    return 1;
  endfunction

  function automatic int multisim_server_send_data_packed(input string name,
                                                          input bit [MAX_DATA_WIDTH-1:0] data,
                                                          input int data_width);
    send_rec_t rec;
    rec.name = name;
    rec.data = data;
    for (int i = 0; i < int'(MAX_DATA_WIDTH); i++)
      if (i >= data_width) rec.data[i] = 1'b0;
    rec.accepted = !(reject.exists(name) && reject[name]);
    send_log.push_back(rec);
    return rec.accepted ? 1 : 0;
  endfunction
endpackage

module multisim_server_push_mc
  import multisim_server_push_mc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  string                              server_name,
  input  logic [NUM_CHANNELS-1:0]            data_vld,
  output logic [NUM_CHANNELS-1:0]            data_rdy,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data,
  output logic                               idle
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned RW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  typedef enum logic [1:0] {
    WAIT_NAME = 2'd0,
    START     = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    started;
  logic [DATA_WIDTH-1:0]   mem   [NUM_CHANNELS][FIFO_DEPTH];
  logic [PW-1:0]           wptr  [NUM_CHANNELS];
  logic [PW-1:0]           rptr  [NUM_CHANNELS];
  logic [CW-1:0]           count [NUM_CHANNELS];
  logic [RW-1:0]           rr_ptr, sel, rr_next;
  logic                    found, all_empty, rest_empty;
  logic [NUM_CHANNELS-1:0] push;

`ifdef MULTISIM_SERVER_PUSH_MC_STATS_EN
  logic [63:0] sent        [NUM_CHANNELS];
  logic [63:0] rejected    [NUM_CHANNELS];
  logic [63:0] full_cycles [NUM_CHANNELS];
`endif

  function automatic string chan_name(input string base, input int unsigned idx);
    if (NUM_CHANNELS == 1) return base;
    return $sformatf("%s_%0d", base, idx);
  endfunction

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_NAME: if (rst_n && server_name != "") state_d = START;
      START:     if (rst_n) state_d = RUN;
      RUN:       state_d = RUN;
      default:   state_d = WAIT_NAME;
    endcase
  end

  assign started = (state_q == RUN);

  // Ready comes from the registered count only, so a full FIFO stays not-ready on its pop cycle.
  always_comb begin
    data_rdy = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++)
      data_rdy[i] = started && rst_n && (count[i] != CW'(FIFO_DEPTH));
  end

  assign push = data_vld & data_rdy;

  always_comb begin
    found      = 1'b0;
    sel        = '0;
    all_empty  = 1'b1;
    rest_empty = 1'b1;
    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
      if (!found && count[(32'(rr_ptr) + k) % NUM_CHANNELS] != '0) begin
        found = 1'b1;
        sel   = RW'((32'(rr_ptr) + k) % NUM_CHANNELS);
      end
    end
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (count[i] != '0) begin
        all_empty = 1'b0;
        if (i != 32'(sel)) rest_empty = 1'b0;
      end
    end
  end

  assign rr_next = RW'((32'(sel) + 32'd1) % NUM_CHANNELS);

  // Startup runs once per simulation; rst_n never returns the FSM to WAIT_NAME.
  always_ff @(posedge clk) begin
    state_q <= state_d;
    if (state_q == START && state_d == RUN)
      for (int unsigned i = 0; i < NUM_CHANNELS; i++)
        void'(multisim_server_start(chan_name(server_name, i)));
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CHANNELS; i++)
      if (push[i]) mem[i][wptr[i]] <= data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Push updates are applied first; the arbitration winner's count assignment overrides its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        wptr[i]  <= '0;
        rptr[i]  <= '0;
        count[i] <= '0;
`ifdef MULTISIM_SERVER_PUSH_MC_STATS_EN
        sent[i]        <= '0;
        rejected[i]    <= '0;
        full_cycles[i] <= '0;
`endif
      end
      rr_ptr <= '0;
      idle   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        if (push[i]) wptr[i] <= wptr[i] + 1'b1;
        count[i] <= count[i] + CW'(push[i]);
`ifdef MULTISIM_SERVER_PUSH_MC_STATS_EN
        if (started && !data_rdy[i]) full_cycles[i] <= full_cycles[i] + 64'd1;
`endif
      end
      idle <= (state_d == RUN) && (push == '0) && all_empty;
      if (started && found) begin
        rr_ptr <= rr_next;
        if ((multisim_server_send_data_packed(chan_name(server_name, 32'(sel)),
                                              MAX_DATA_WIDTH'(mem[sel][rptr[sel]]),
                                              int'(DATA_WIDTH)) & 1) != 0) begin
          rptr[sel]  <= rptr[sel] + 1'b1;
          count[sel] <= count[sel] + CW'(push[sel]) - 1'b1;
          idle       <= (push == '0) && (count[sel] == CW'(1)) && rest_empty;
`ifdef MULTISIM_SERVER_PUSH_MC_STATS_EN
          sent[sel] <= sent[sel] + 64'd1;
        end else begin
          rejected[sel] <= rejected[sel] + 64'd1;
`endif
        end
      end
    end
  end

`ifdef MULTISIM_SERVER_PUSH_MC_STATS_EN
  final begin
    for (int unsigned i = 0; i < NUM_CHANNELS; i++)
      $display("%s sent=%0d rejected=%0d full_cycles=%0d",
               chan_name(server_name, i), sent[i], rejected[i], full_cycles[i]);
  end
`endif

endmodule

// File: tb/tb_multisim_server_push_mc.sv
// Bench for multisim_server_push_mc: queue-based reference model of FIFOs, round-robin and server replies.
module tb_multisim_server_push_mc;
  import multisim_server_push_mc_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned W = 64;
  localparam int unsigned D = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  string          server_name = "";
  logic [N-1:0]   data_vld = '0;
  logic [N-1:0]   data_rdy;
  logic [N*W-1:0] data = '0;
  logic           idle;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string        name;
    logic [W-1:0] data;
    bit           ok;
  } exp_rec_t;

  exp_rec_t     exp_log[$];
  logic [W-1:0] mq [N][$];
  int unsigned  m_rr = 0;
  bit           m_started = 1'b0;
  bit           m_reject [N];

  always #5 clk = ~clk;

  multisim_server_push_mc #(
    .DATA_WIDTH  (W),
    .NUM_CHANNELS(N),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .server_name(server_name),
    .data_vld   (data_vld),
    .data_rdy   (data_rdy),
    .data       (data),
    .idle       (idle)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic string cname(input int unsigned c);
    return $sformatf("srv_%0d", c);
  endfunction

  function automatic logic [N*W-1:0] slot(input int unsigned c, input logic [W-1:0] v);
    logic [N*W-1:0] r;
    r = '0;
    r[c*W +: W] = v;
    return r;
  endfunction

  function automatic logic [N*W-1:0] rand_data();
    logic [N*W-1:0] r;
    for (int unsigned i = 0; i < N; i++) r[i*W +: W] = {$urandom, $urandom};
    return r;
  endfunction

  function automatic logic [N-1:0] exp_rdy();
    logic [N-1:0] r;
    for (int unsigned i = 0; i < N; i++)
      r[i] = m_started && (rst_n === 1'b1) && (mq[i].size() < int'(D));
    return r;
  endfunction

  function automatic logic exp_idle();
    logic e;
    e = m_started && (rst_n === 1'b1);
    for (int unsigned i = 0; i < N; i++) if (mq[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  function automatic bit model_empty();
    for (int unsigned i = 0; i < N; i++) if (mq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // -1 when the DUT call log equals the model log, else the first differing index.
  function automatic int log_diff();
    int n;
    n = (send_log.size() < exp_log.size()) ? send_log.size() : exp_log.size();
    for (int i = 0; i < n; i++)
      if (send_log[i].name != exp_log[i].name || send_log[i].data[W-1:0] !== exp_log[i].data ||
          send_log[i].accepted != exp_log[i].ok)
        return i;
    return (send_log.size() == exp_log.size()) ? -1 : n;
  endfunction

  task automatic set_reject(input logic [N-1:0] mask);
    for (int unsigned i = 0; i < N; i++) begin
      m_reject[i] = mask[i];
      reject[cname(i)] = mask[i];
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, return 1 time unit after it.
  task automatic drive_cycle(input logic [N-1:0] vld, input logic [N*W-1:0] d);
    logic [N-1:0] acc;
    exp_rec_t     r;
    bit           done;
    data_vld = vld;
    data     = d;
    acc      = vld & exp_rdy();
    @(posedge clk);
    if (rst_n === 1'b1 && m_started) begin
      done = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
        int unsigned c;
        c = (m_rr + k) % N;
        if (!done && mq[c].size() > 0) begin
          r.name = cname(c);
          r.data = mq[c][0];
          r.ok   = !m_reject[c];
          exp_log.push_back(r);
          if (r.ok) void'(mq[c].pop_front());
          m_rr = (c + 1) % N;
          done = 1'b1;
        end
      end
      for (int unsigned i = 0; i < N; i++)
        if (acc[i]) mq[i].push_back(d[i*W +: W]);
    end
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (data_rdy !== '0) begin n_fail++; $display("FAIL reset_rdy: got %b want 0000", data_rdy); end
    n_tests++;
    if (idle !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got %b want 0", idle); end
    rst_n = 1'b1;
  endtask

  task automatic test_startup();
    repeat (10) drive_cycle('0, '0);
    n_tests++;
    if (data_rdy !== '0) begin n_fail++; $display("FAIL startup_noname_rdy: got %b want 0000", data_rdy); end
    n_tests++;
    if (start_log.size() != 0) begin n_fail++; $display("FAIL startup_noname_calls: got %0d want 0", start_log.size()); end
    server_name = "srv";
    for (int k = 0; k < 8; k++) begin
      drive_cycle('0, '0);
      if (data_rdy !== '0) break;
    end
    m_started = 1'b1;
    n_tests++;
    if (start_log.size() != int'(N)) begin n_fail++; $display("FAIL startup_ncalls: got %0d want %0d", start_log.size(), N); end
    for (int unsigned i = 0; i < N && i < start_log.size(); i++) begin
      n_tests++;
      if (start_log[i] != cname(i)) begin n_fail++; $display("FAIL startup_name%0d: got %s want %s", i, start_log[i], cname(i)); end
    end
    n_tests++;
    if (data_rdy !== 4'b1111) begin n_fail++; $display("FAIL startup_rdy: got %b want 1111", data_rdy); end
    n_tests++;
    if (idle !== 1'b1) begin n_fail++; $display("FAIL startup_idle: got %b want 1", idle); end
  endtask

  task automatic test_ordering();
    int base;
    set_reject('0);
    base = send_log.size();
    drive_cycle(4'b0100, slot(2, 64'hA1));
    n_tests++;
    if (send_log.size() != base) begin n_fail++; $display("FAIL order_latency0: got %0d sends want 0", send_log.size() - base); end
    drive_cycle(4'b0100, slot(2, 64'hA2));
    n_tests++;
    if (send_log.size() != base + 1 || send_log[send_log.size()-1].name != "srv_2" ||
        send_log[send_log.size()-1].data[W-1:0] !== 64'hA1) begin
      n_fail++;
      $display("FAIL order_first: got %0d new sends want 1 (srv_2 a1)", send_log.size() - base);
    end
    drive_cycle(4'b0100, slot(2, 64'hA3));
    repeat (4) begin
      drive_cycle('0, '0);
      n_tests++;
      if ({data_rdy, idle} !== {exp_rdy(), exp_idle()}) begin
        n_fail++; $display("FAIL order_status: got %b/%b want %b/%b", data_rdy, idle, exp_rdy(), exp_idle());
      end
    end
    n_tests++;
    if (log_diff() != -1) begin n_fail++; $display("FAIL order_log: differs at %0d (got %0d want %0d calls)", log_diff(), send_log.size(), exp_log.size()); end
    n_tests++;
    if (idle !== 1'b1) begin n_fail++; $display("FAIL order_idle: got %b want 1", idle); end
  endtask

  task automatic test_fairness();
    int base, ok_cnt;
    set_reject('1);
    drive_cycle('1, rand_data());
    drive_cycle('1, rand_data());
    set_reject(4'b0010);
    base = send_log.size();
    for (int k = 0; k < 16; k++) begin
      if (mq[0].size() == 0 && mq[2].size() == 0 && mq[3].size() == 0) break;
      drive_cycle('0, '0);
      n_tests++;
      if ({data_rdy, idle} !== {exp_rdy(), exp_idle()}) begin
        n_fail++; $display("FAIL fair_status: got %b/%b want %b/%b", data_rdy, idle, exp_rdy(), exp_idle());
      end
    end
    ok_cnt = 0;
    for (int i = base; i < send_log.size(); i++) if (send_log[i].accepted) ok_cnt++;
    n_tests++;
    if (ok_cnt != 6) begin n_fail++; $display("FAIL fair_accepts: got %0d want 6", ok_cnt); end
    n_tests++;
    if (log_diff() != -1) begin n_fail++; $display("FAIL fair_log: differs at %0d (got %0d want %0d calls)", log_diff(), send_log.size(), exp_log.size()); end
    n_tests++;
    if (idle !== 1'b0) begin n_fail++; $display("FAIL fair_retained: idle got %b want 0", idle); end
    set_reject('0);
    for (int k = 0; k < 16 && !model_empty(); k++) drive_cycle('0, '0);
    n_tests++;
    if (idle !== 1'b1) begin n_fail++; $display("FAIL fair_drain_idle: got %b want 1", idle); end
  endtask

  task automatic test_full();
    logic [N-1:0] want;
    set_reject(4'b0001);
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (data_rdy[0] !== (k < 4)) begin n_fail++; $display("FAIL full_rdy%0d: got %b want %b", k, data_rdy[0], k < 4); end
      drive_cycle(4'b0001, slot(0, 64'hF0 + 64'(k)));
    end
    want = exp_rdy();
    n_tests++;
    if (data_rdy !== want) begin n_fail++; $display("FAIL full_hold: got %b want %b", data_rdy, want); end
    set_reject('0);
    drive_cycle('0, '0);
    n_tests++;
    if (data_rdy[0] !== 1'b1) begin n_fail++; $display("FAIL full_release: got %b want 1", data_rdy[0]); end
    for (int k = 0; k < 16 && !model_empty(); k++) drive_cycle('0, '0);
    n_tests++;
    if (log_diff() != -1) begin n_fail++; $display("FAIL full_log: differs at %0d (got %0d want %0d calls)", log_diff(), send_log.size(), exp_log.size()); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      set_reject(($urandom_range(0, 3) == 0) ? N'($urandom) : '0);
      drive_cycle(N'($urandom), rand_data());
      n_tests++;
      if ({data_rdy, idle} !== {exp_rdy(), exp_idle()}) begin
        n_fail++; $display("FAIL rand_status%0d: got %b/%b want %b/%b", k, data_rdy, idle, exp_rdy(), exp_idle());
      end
    end
    set_reject('0);
    for (int k = 0; k < 40 && !model_empty(); k++) drive_cycle('0, '0);
    n_tests++;
    if (log_diff() != -1) begin n_fail++; $display("FAIL rand_log: differs at %0d (got %0d want %0d calls)", log_diff(), send_log.size(), exp_log.size()); end
    n_tests++;
    if (idle !== 1'b1) begin n_fail++; $display("FAIL rand_idle: got %b want 1", idle); end
  endtask

  task automatic test_reset_midstream();
    int base_s, base_st;
    set_reject('1);
    drive_cycle(4'b1010, slot(3, 64'h31) | slot(1, 64'h11));
    drive_cycle(4'b1000, slot(3, 64'h32));
    drive_cycle(4'b1000, slot(3, 64'h33));
    for (int k = 0; k < 4 && m_rr != 2; k++) drive_cycle('0, '0);
    base_s  = send_log.size();
    base_st = start_log.size();
    #2;
    rst_n = 1'b0;
    for (int unsigned i = 0; i < N; i++) mq[i].delete();
    m_rr = 0;
    #1;
    n_tests++;
    if (data_rdy !== '0) begin n_fail++; $display("FAIL rstmid_rdy: got %b want 0000", data_rdy); end
    n_tests++;
    if (idle !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got %b want 0", idle); end
    repeat (3) drive_cycle('1, rand_data());
    n_tests++;
    if (send_log.size() != base_s) begin n_fail++; $display("FAIL rstmid_nosend: got %0d sends want 0", send_log.size() - base_s); end
    rst_n = 1'b1;
    set_reject('0);
    drive_cycle('0, '0);
    n_tests++;
    if (idle !== 1'b1 || data_rdy !== 4'b1111) begin n_fail++; $display("FAIL rstmid_release: got %b/%b want 1111/1", data_rdy, idle); end
    n_tests++;
    if (start_log.size() != base_st) begin n_fail++; $display("FAIL rstmid_restart: got %0d calls want 0", start_log.size() - base_st); end
    drive_cycle(4'b1001, slot(0, 64'hC0) | slot(3, 64'hC3));
    for (int k = 0; k < 8 && !model_empty(); k++) drive_cycle('0, '0);
    n_tests++;
    if (log_diff() != -1) begin n_fail++; $display("FAIL rstmid_log: differs at %0d (got %0d want %0d calls)", log_diff(), send_log.size(), exp_log.size()); end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_ordering();
    test_fairness();
    test_full();
    test_random();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
